// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Program counter and branch-resolution stage. Drives the
//            instruction ROM address, resolves je/jne against three saved
//            target registers and the zero flag, sequences Start/Done and
//            counts executed cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic [7:0]       OffsetIn,
    input  logic             ZeroIn,
    input  logic             FlagWe,
    output logic [PC_W-1:0]  ProgAddr,
    output logic             Running,
    output logic             Done,
    output logic             ZeroFlag,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] C_START = PC_W'(START_ADDR);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pcreg_q [1:3];
    logic [PC_W-1:0]  pcreg_d [1:3];
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, done_q;

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_off;
    logic [PC_W-1:0]  sel_target;
    logic             sel_nz;
    logic             do_save;

    // Address arithmetic; the offset is sign-extended and both sums wrap
    // naturally at PC_W bits.
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_off = pc_q + {{(PC_W-8){OffsetIn[7]}}, OffsetIn};
    assign sel_nz = (PCRegSelect != 2'b00);

    // Saves only fire when no jump shares the cycle; a jump wins.
    assign do_save = sel_nz && !JumpEqual && !JumpNotEqual;

    // Target selection from the saved-PC bank (sel=00 never used as a target).
    always_comb begin
        sel_target = pcreg_q[1];
        case (PCRegSelect)
            2'b10:   sel_target = pcreg_q[2];
            2'b11:   sel_target = pcreg_q[3];
            default: sel_target = pcreg_q[1];
        endcase
    end

    // Next-state computation for FSM, PC, saved targets, flag and counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        for (int i = 1; i <= 3; i++) begin
            pcreg_d[i] = pcreg_q[i];
        end

        case (state_q)
            ST_RUN: begin
                // Every RUN cycle counts, including the halting one.
                if (!(&cnt_q)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (Ack) begin
                    state_d = ST_DONE;
                end else begin
                    // Branches see the flag as it stood before this edge.
                    if (JumpEqual && sel_nz) begin
                        pc_d = zero_q ? sel_target : pc_inc;
                    end else if (JumpNotEqual && sel_nz) begin
                        pc_d = zero_q ? pc_inc : sel_target;
                    end else begin
                        pc_d = pc_inc;
                    end

                    for (int i = 1; i <= 3; i++) begin
                        if (do_save && (PCRegSelect == 2'(i))) begin
                            pcreg_d[i] = OffsetEn ? pc_off : pc_inc;
                        end
                    end

                    if (FlagWe) begin
                        zero_d = ZeroIn;
                    end
                end
            end
            default: begin
                // IDLE and DONE: only Start has any effect; PCregs survive.
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = C_START;
                    zero_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State register with registered Running/Done decodes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 1; i <= 3; i++) begin
                pcreg_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            zero_q    <= zero_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            for (int i = 1; i <= 3; i++) begin
                pcreg_q[i] <= pcreg_d[i];
            end
        end
    end

    assign ProgAddr   = pc_q;
    assign Running    = running_q;
    assign Done       = done_q;
    assign ZeroFlag   = zero_q;
    assign CycleCount = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed scenarios followed
//            by random instruction streams, compared cycle by cycle against a
//            behavioural model of the program-counter rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int PC_W   = 10;
    localparam int CNT_W  = 6;
    localparam int START  = 0;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             Start = 1'b0;
    logic             Ack = 1'b0;
    logic             JumpEqual = 1'b0;
    logic             JumpNotEqual = 1'b0;
    logic             OffsetEn = 1'b0;
    logic [1:0]       PCRegSelect = 2'b00;
    logic [7:0]       OffsetIn = 8'h00;
    logic             ZeroIn = 1'b0;
    logic             FlagWe = 1'b0;
    logic [PC_W-1:0]  ProgAddr;
    logic             Running;
    logic             Done;
    logic             ZeroFlag;
    logic [CNT_W-1:0] CycleCount;

    fetch_unit #(.PC_W(PC_W), .START_ADDR(START), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual),
        .OffsetEn(OffsetEn), .PCRegSelect(PCRegSelect), .OffsetIn(OffsetIn),
        .ZeroIn(ZeroIn), .FlagWe(FlagWe), .ProgAddr(ProgAddr),
        .Running(Running), .Done(Done), .ZeroFlag(ZeroFlag),
        .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode is "idle", "run" or "done" in words, numbers as ints.
    string m_mode;
    int    m_pc;
    int    m_reg [1:3];
    int    m_zero;
    int    m_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = "idle";
        m_pc = 0;
        m_zero = 0;
        m_cnt = 0;
        for (int i = 1; i <= 3; i++) m_reg[i] = 0;
    endtask

    // One clock of the architectural rules, applied to the current inputs.
    task automatic model_step();
        int nxt;
        if (m_mode == "run") begin
            m_cnt = (m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX;
            if (Ack) begin
                m_mode = "done";
            end else begin
                int sel = int'(PCRegSelect);
                nxt = (m_pc + 1) % PC_MOD;
                if (JumpEqual && sel != 0) begin
                    if (m_zero == 1) nxt = m_reg[sel];
                end else if (JumpNotEqual && sel != 0) begin
                    if (m_zero == 0) nxt = m_reg[sel];
                end else if (sel != 0) begin
                    if (OffsetEn)
                        m_reg[sel] = (m_pc + int'($signed(OffsetIn)) + PC_MOD) % PC_MOD;
                    else
                        m_reg[sel] = (m_pc + 1) % PC_MOD;
                end
                if (FlagWe) m_zero = int'(ZeroIn);
                m_pc = nxt;
            end
        end else if (Start) begin
            m_mode = "run";
            m_pc = START;
            m_zero = 0;
            m_cnt = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, int'(ProgAddr), m_pc);
        chk({tag, ".run"},  int'(Running), (m_mode == "run") ? 1 : 0);
        chk({tag, ".done"}, int'(Done), (m_mode == "done") ? 1 : 0);
        chk({tag, ".zf"},   int'(ZeroFlag), m_zero);
        chk({tag, ".cnt"},  int'(CycleCount), m_cnt);
    endtask

    // Drive one instruction's decode outputs, clock it, then compare.
    task automatic cyc(input logic st, input logic ack, input logic je,
                       input logic jne, input logic oe, input logic [1:0] sel,
                       input logic [7:0] off, input logic fwe, input logic z);
        Start = st; Ack = ack; JumpEqual = je; JumpNotEqual = jne;
        OffsetEn = oe; PCRegSelect = sel; OffsetIn = off; FlagWe = fwe; ZeroIn = z;
        model_step();
        @(posedge Clk);
        #1;
        check_all("cyc");
    endtask

    task automatic plain();
        cyc(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
    endtask

    // Plain instructions until the PC reaches target, within a cycle budget.
    task automatic run_to(input int target);
        int budget = 2000;
        while (int'(ProgAddr) != target && budget > 0) begin
            plain();
            budget--;
        end
        chk("run_to.reached", int'(ProgAddr), target);
    endtask

    task automatic async_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        chk("idle.addr", int'(ProgAddr), 0);

        // Start, then eight plain cycles.
        cyc(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        chk("start.run", int'(Running), 1);
        repeat (8) plain();
        chk("eight.addr", int'(ProgAddr), 8);
        chk("eight.cnt", int'(CycleCount), 8);

        // Restart from 0, save PC+1 at 3, compare at 10, je at 11.
        cyc(1, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cyc(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        run_to(3);
        cyc(0, 0, 0, 0, 0, 2'b01, 8'h00, 0, 0);
        run_to(10);
        cyc(0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 1);
        cyc(0, 0, 1, 0, 0, 2'b01, 8'h00, 0, 0);
        chk("je_taken.addr", int'(ProgAddr), 4);
        run_to(10);
        cyc(0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 0);
        cyc(0, 0, 1, 0, 0, 2'b01, 8'h00, 0, 0);
        chk("je_not_taken.addr", int'(ProgAddr), 12);

        // Offset save (-10) at 20, jne back with flag clear.
        run_to(20);
        cyc(0, 0, 0, 0, 1, 2'b10, 8'hF6, 0, 0);
        cyc(0, 0, 0, 1, 0, 2'b10, 8'h00, 0, 0);
        chk("jne_taken.addr", int'(ProgAddr), 10);

        // je with sel=00 and flag set is a no-op branch.
        cyc(0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 1);
        cyc(0, 0, 1, 0, 0, 2'b00, 8'h00, 0, 0);
        chk("je_sel0.addr", int'(ProgAddr), 12);

        // Halt at 15 with a je alongside; jumps ignored while done.
        run_to(15);
        cyc(0, 1, 1, 0, 0, 2'b01, 8'h00, 0, 0);
        chk("halt.done", int'(Done), 1);
        chk("halt.addr", int'(ProgAddr), 15);
        cyc(0, 0, 1, 1, 1, 2'b11, 8'h05, 1, 0);
        cyc(0, 0, 0, 0, 0, 2'b01, 8'h05, 1, 1);
        chk("done_hold.addr", int'(ProgAddr), 15);

        // Restart: PCregs retained (PCreg1 = 4).
        cyc(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        chk("restart.cnt", int'(CycleCount), 0);
        cyc(0, 0, 0, 1, 0, 2'b01, 8'h00, 0, 0);
        chk("retained.addr", int'(ProgAddr), 4);

        // Long climb to the top of the address space (counter saturates).
        run_to(1020);
        chk("sat.cnt", int'(CycleCount), CNTMAX);
        cyc(0, 0, 0, 0, 1, 2'b11, 8'h08, 0, 0);
        run_to(1023);
        plain();
        chk("wrap.addr", int'(ProgAddr), 0);
        cyc(0, 0, 0, 1, 0, 2'b11, 8'h00, 0, 0);
        chk("wrap_save.addr", int'(ProgAddr), 4);

        // Abort mid-run.
        async_reset();
        chk("abort.run", int'(Running), 0);
        plain();

        // Random instruction streams with occasional halts, restarts, resets.
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if (k % 700 == 350) begin
                async_reset();
            end else begin
                cyc(($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 40) == 0),
                    r[0] & r[1], r[2] & r[3],
                    1'($urandom), 2'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Program counter and branch-resolution stage that directly consumes the control decoder's branch outputs (JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, Ack). Each cycle it drives the instruction ROM address and computes the next PC. It holds three saved-target registers (PCreg1–3) loaded by `spc` and used by `je`/`jne`, plus the architectural zero flag. It also sequences the Start/Done program handshake and counts executed cycles.

## Interface
- PC_W, 10: PC / instruction-ROM address width.
- START_ADDR, 0: PC value loaded on Start.
- CNT_W, 16: width of the executed-cycle counter.

- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  level; begins execution from START_ADDR (IDLE/DONE only).
- Ack  input  1  halt indication from the control decoder.
- JumpEqual  input  1  current instruction is `je`.
- JumpNotEqual  input  1  current instruction is `jne`.
- OffsetEn  input  1  `spc` saves PC+offset instead of PC+1.
- PCRegSelect  input  2  00 none; 01/10/11 select PCreg1/2/3.
- OffsetIn  input  8  r8 read data, treated as two's-complement offset.
- ZeroIn  input  1  ALU zero output for the current instruction.
- FlagWe  input  1  current instruction updates the zero flag.
- ProgAddr  output  PC_W  registered PC; drives the instruction ROM.
- Running  output  1  high in RUN.
- Done  output  1  high in DONE.
- ZeroFlag  output  1  registered zero flag.
- CycleCount  output  CNT_W  RUN cycles since the last Start; saturating.

## Operation
- FSM states: IDLE (after reset), RUN, DONE.
  - IDLE→RUN when Start=1. The same edge loads PC←START_ADDR, clears ZeroFlag and CycleCount.
  - RUN→DONE when Ack=1. PC, PCregs and ZeroFlag hold. CycleCount increments for this final cycle.
  - DONE→RUN when Start=1, with the same loads as IDLE→RUN.
  - Start in RUN is ignored.
- Branch and control inputs are evaluated only in RUN. In IDLE/DONE, PC, PCregs and ZeroFlag hold.
- Next-PC priority in RUN, top first:
  1. Ack=1 → PC holds.
  2. JumpEqual=1 and PCRegSelect≠0 → PC←PCreg[sel] if ZeroFlag=1, else PC+1.
  3. JumpNotEqual=1 and PCRegSelect≠0 → PC←PCreg[sel] if ZeroFlag=0, else PC+1.
  4. Otherwise → PC+1.
- Jump with PCRegSelect=00 is a no-op branch: PC+1.
- Save (`spc`): in RUN, Ack=0, both jump flags=0 and PCRegSelect≠0 → PCreg[sel] is written.
  - OffsetEn=0 → written value is PC+1.
  - OffsetEn=1 → written value is PC + sign-extend(OffsetIn).
- A PCreg write with either jump flag also high is suppressed: the jump takes effect, no save.
- All address arithmetic is modulo 2^PC_W. PC+1 from all-ones wraps to 0. Offset sums wrap the same way.
- Zero flag: in RUN with Ack=0 and FlagWe=1, ZeroFlag←ZeroIn. Branches always use the pre-edge ZeroFlag, never the same-cycle ZeroIn.
- CycleCount increments every RUN cycle and saturates at all-ones.

## Timing
- Reset (asynchronous, Reset=0) sets:
  - state IDLE, ProgAddr=0, PCreg1–3=0, ZeroFlag=0, CycleCount=0;
  - Running=0, Done=0.
- Reset asserted mid-RUN aborts immediately. No further writes occur until Start after reset release.
- Single-cycle fetch: ProgAddr is a register. The ROM and decoder are combinational from ProgAddr, so branch inputs for the instruction at ProgAddr are valid in the same cycle. The next PC appears after the following rising edge.
- Branch latency is zero bubbles. The taken target is on ProgAddr the cycle after the `je`/`jne`.
- PCreg written at edge N is usable by a jump in cycle N+1. Back-to-back `spc`, `je` is legal.
- Flag written at edge N is visible to a branch in cycle N+1. A compare immediately followed by a branch is legal.
- Running and Done are registered state decodes, valid the cycle after the transition edge.

## Test plan
- Reset/start: Reset=0 then release; Start pulse → ProgAddr=0 and Running=1 the next cycle. Eight plain cycles → ProgAddr steps 0…8, CycleCount=8.
- Save and taken je:
  - At PC=3, `spc` sel=01, OffsetEn=0 → PCreg1=4.
  - At PC=10, FlagWe=1, ZeroIn=1; at PC=11, je sel=01 → ProgAddr=4 next cycle.
  - Same sequence with ZeroIn=0 → ProgAddr=12.
- Offset save and jne: at PC=20, `spc` sel=10, OffsetEn=1, OffsetIn=8'hF6 (−10) → PCreg2=10. With ZeroFlag=0, jne sel=10 → ProgAddr=10.
- Wrap: force PC=1023 (PC_W=10), plain instruction → ProgAddr=0. At PC=1020, OffsetEn save with OffsetIn=8 → PCreg=4.
- Halt and restart:
  - Ack=1 at PC=15 → Done=1 next cycle, ProgAddr stays 15, CycleCount frozen. Jump inputs are ignored.
  - Start → ProgAddr=0, ZeroFlag=0, CycleCount=0, PCregs retained.
- Corner priority:
  - je with sel=00 and ZeroFlag=1 → PC+1.
  - Ack together with JumpEqual → hold.
  - Reset=0 mid-RUN → all outputs at reset values without a clock edge.
